// File: rtl/spi_frame_monitor.sv
// ============================================================================
// spi_frame_monitor
// ----------------------------------------------------------------------------
// Passive monitor that sits on the SPI bus driven by the stimulus master and
// rebuilds each command / address / (dummy) / data frame it sees. Every frame
// that terminates, cleanly or not, produces one record that is pushed into a
// small FIFO for on-board checking or a UART dump.
//
// Ports
//   clk_i      in   FPGA clock, shared with the SPI master
//   rst_i      in   synchronous active-high reset
//   spi_sclk   in   SPI clock from the master (already in the clk_i domain)
//   spi_sdo    in   master -> SoC data (command, address, write data)
//   spi_sdi    in   SoC -> master data (read data)
//   spi_cs     in   chip select, active low
//   rec_valid  out  head record of the FIFO is valid
//   rec_ready  in   consumer takes the head record
//   rec_cmd    out  decoded opcode of the head record
//   rec_addr   out  decoded address of the head record
//   rec_data   out  write data or read data of the head record
//   rec_err    out  head record is truncated or carries an unknown opcode
//   frame_cnt  out  number of terminated frames, wraps at 256
//   overflow   out  sticky flag, a record was lost because the FIFO was full
// ============================================================================
module spi_frame_monitor #(
   parameter logic [7:0] WRITE_CMD  = 8'h02,
   parameter logic [7:0] READ_CMD   = 8'h0B,
   parameter int         DUMMY_BITS = 34,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        spi_sclk,
   input  logic        spi_sdo,
   input  logic        spi_sdi,
   input  logic        spi_cs,
   output logic        rec_valid,
   input  logic        rec_ready,
   output logic [7:0]  rec_cmd,
   output logic [31:0] rec_addr,
   output logic [31:0] rec_data,
   output logic        rec_err,
   output logic [7:0]  frame_cnt,
   output logic        overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int RW = 8 + 32 + 32 + 1;

   // ST_READY is the state after a completed frame while CS is still low:
   // the next rising edge is the first command bit of a back-to-back frame.
   // ST_HUNT swallows the rest of a frame with an unknown opcode.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_READY,
      ST_HUNT
   } state_t;

   state_t        r_state;
   state_t        w_stateNxt;
   logic          r_sclkQ;
   logic          w_rise;
   logic [7:0]    r_cmd;
   logic [7:0]    w_cmdNxt;
   logic [31:0]   r_addr;
   logic [31:0]   w_addrNxt;
   logic [31:0]   r_data;
   logic [31:0]   w_dataNxt;
   logic [5:0]    r_bitCnt;
   logic [5:0]    w_bitCntNxt;
   logic          w_push;
   logic [RW-1:0] w_pushRec;

   logic          w_isRead;
   logic          w_cmdValid;
   logic          w_dataBit;
   logic [7:0]    w_cmdShift;
   logic [31:0]   w_addrShift;
   logic [31:0]   w_dataShift;

   logic [RW-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wrPtr;
   logic [AW-1:0] r_rdPtr;
   logic [AW:0]   r_count;
   logic          w_full;
   logic          w_pop;
   logic          w_write;
   logic [RW-1:0] w_head;

   // A rising SCLK edge only counts while the slave is selected. Because
   // SCLK toggles at most once per clk_i cycle, comparing against the
   // previous-cycle value never misses an edge.
   assign w_rise = ~r_sclkQ & spi_sclk & ~spi_cs;

   // Shifted versions of each field with the current bit appended, MSB
   // first. The opcode check looks at the shifted value so that it can be
   // made on the very edge that delivers the eighth command bit.
   assign w_isRead    = (r_cmd == READ_CMD);
   assign w_cmdShift  = {r_cmd[6:0], spi_sdo};
   assign w_addrShift = {r_addr[30:0], spi_sdo};
   assign w_dataBit   = w_isRead ? spi_sdi : spi_sdo;
   assign w_dataShift = {r_data[30:0], w_dataBit};
   assign w_cmdValid  = (w_cmdShift == WRITE_CMD) || (w_cmdShift == READ_CMD);

   // Next-state and datapath logic. The bit counter is loaded with the
   // phase length minus one and the phase ends on the edge where it reads
   // zero. Fields are cleared at the start of every frame, so a truncated
   // record naturally carries zeros in the fields that never got shifted.
   // CS going high in the middle of a phase wins over everything else and
   // flushes whatever was collected as an error record.
   always_comb begin
      w_stateNxt  = r_state;
      w_cmdNxt    = r_cmd;
      w_addrNxt   = r_addr;
      w_dataNxt   = r_data;
      w_bitCntNxt = r_bitCnt;
      w_push      = 1'b0;
      w_pushRec   = '0;

      case (r_state)
         ST_IDLE, ST_READY: begin
            if (w_rise) begin
               w_cmdNxt    = {7'd0, spi_sdo};
               w_addrNxt   = '0;
               w_dataNxt   = '0;
               w_bitCntNxt = 6'd6;
               w_stateNxt  = ST_CMD;
            end else if (spi_cs) begin
               w_stateNxt = ST_IDLE;
            end
         end

         ST_CMD: begin
            if (spi_cs) begin
               w_push     = 1'b1;
               w_pushRec  = {r_cmd, r_addr, r_data, 1'b1};
               w_stateNxt = ST_IDLE;
            end else if (w_rise) begin
               w_cmdNxt    = w_cmdShift;
               w_bitCntNxt = r_bitCnt - 6'd1;
               if (r_bitCnt == 6'd0) begin
                  if (w_cmdValid) begin
                     w_bitCntNxt = 6'd31;
                     w_stateNxt  = ST_ADDR;
                  end else begin
                     w_push     = 1'b1;
                     w_pushRec  = {w_cmdShift, 32'd0, 32'd0, 1'b1};
                     w_stateNxt = ST_HUNT;
                  end
               end
            end
         end

         ST_ADDR: begin
            if (spi_cs) begin
               w_push     = 1'b1;
               w_pushRec  = {r_cmd, r_addr, r_data, 1'b1};
               w_stateNxt = ST_IDLE;
            end else if (w_rise) begin
               w_addrNxt   = w_addrShift;
               w_bitCntNxt = r_bitCnt - 6'd1;
               if (r_bitCnt == 6'd0) begin
                  if (w_isRead) begin
                     w_bitCntNxt = 6'(DUMMY_BITS - 1);
                     w_stateNxt  = ST_DUMMY;
                  end else begin
                     w_bitCntNxt = 6'd31;
                     w_stateNxt  = ST_DATA;
                  end
               end
            end
         end

         ST_DUMMY: begin
            if (spi_cs) begin
               w_push     = 1'b1;
               w_pushRec  = {r_cmd, r_addr, r_data, 1'b1};
               w_stateNxt = ST_IDLE;
            end else if (w_rise) begin
               w_bitCntNxt = r_bitCnt - 6'd1;
               if (r_bitCnt == 6'd0) begin
                  w_bitCntNxt = 6'd31;
                  w_stateNxt  = ST_DATA;
               end
            end
         end

         ST_DATA: begin
            if (spi_cs) begin
               w_push     = 1'b1;
               w_pushRec  = {r_cmd, r_addr, r_data, 1'b1};
               w_stateNxt = ST_IDLE;
            end else if (w_rise) begin
               w_dataNxt   = w_dataShift;
               w_bitCntNxt = r_bitCnt - 6'd1;
               if (r_bitCnt == 6'd0) begin
                  w_push     = 1'b1;
                  w_pushRec  = {r_cmd, r_addr, w_dataShift, 1'b0};
                  w_stateNxt = ST_READY;
               end
            end
         end

         ST_HUNT: begin
            if (spi_cs) begin
               w_stateNxt = ST_IDLE;
            end
         end

         default: begin
            w_stateNxt = ST_IDLE;
         end
      endcase
   end

   // Frame decoder registers, including the SCLK history used for edge
   // detection.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= ST_IDLE;
         r_sclkQ  <= 1'b0;
         r_cmd    <= '0;
         r_addr   <= '0;
         r_data   <= '0;
         r_bitCnt <= '0;
      end else begin
         r_state  <= w_stateNxt;
         r_sclkQ  <= spi_sclk;
         r_cmd    <= w_cmdNxt;
         r_addr   <= w_addrNxt;
         r_data   <= w_dataNxt;
         r_bitCnt <= w_bitCntNxt;
      end
   end

   // A full FIFO still accepts a record when the head leaves in the same
   // cycle, so nothing is lost in that case.
   assign w_full    = (r_count == (AW+1)'(FIFO_DEPTH));
   assign rec_valid = (r_count != '0);
   assign w_pop     = rec_valid & rec_ready;
   assign w_write   = w_push & (~w_full | w_pop);

   // Record storage. It carries no reset because every entry is written
   // before the count makes it visible.
   always_ff @(posedge clk_i) begin
      if (w_write) begin
         r_mem[r_wrPtr] <= w_pushRec;
      end
   end

   // FIFO pointers and occupancy, the frame counter (counts every push
   // attempt, dropped or not) and the sticky overflow flag. The depth is a
   // power of two, so the pointers wrap on their own.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wrPtr   <= '0;
         r_rdPtr   <= '0;
         r_count   <= '0;
         frame_cnt <= '0;
         overflow  <= 1'b0;
      end else begin
         if (w_write) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_push) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
         if (w_push & ~w_write) begin
            overflow <= 1'b1;
         end
      end
   end

   // Record outputs come from the head entry and are held at zero while
   // the FIFO is empty, which also gives clean values straight out of reset.
   assign w_head   = r_mem[r_rdPtr];
   assign rec_cmd  = rec_valid ? w_head[72:65] : 8'd0;
   assign rec_addr = rec_valid ? w_head[64:33] : 32'd0;
   assign rec_data = rec_valid ? w_head[32:1]  : 32'd0;
   assign rec_err  = rec_valid ? w_head[0]     : 1'b0;

endmodule

// File: tb/tb_spi_frame_monitor.sv
// ============================================================================
// tb_spi_frame_monitor
// ----------------------------------------------------------------------------
// Self-checking bench for spi_frame_monitor. Frames are bit-banged on the SPI
// pins at SCLK = clk/2. Expected records come from a table of hand-computed
// vectors and, for the random part, from a frame-level model that derives the
// record from the number of bits delivered before CS went high.
// ============================================================================
module tb_spi_frame_monitor;

   localparam int FIFO_DEPTH = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        spi_sclk;
   logic        spi_sdo;
   logic        spi_sdi;
   logic        spi_cs;
   logic        rec_valid;
   logic        rec_ready;
   logic [7:0]  rec_cmd;
   logic [31:0] rec_addr;
   logic [31:0] rec_data;
   logic        rec_err;
   logic [7:0]  frame_cnt;
   logic        overflow;

   int totalChecks = 0;
   int badChecks   = 0;

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] addr;
      logic [31:0] data;
   } frame_t;

   typedef struct {
      logic [7:0]  cmd;
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
   } rec_t;

   typedef struct {
      frame_t f;
      int     cut;
      bit     keepCs;
      rec_t   exp;
   } vector_t;

   rec_t       expQ[$];
   rec_t       monExp;
   logic [7:0] expFrameCnt = 8'd0;
   logic       expOverflow = 1'b0;
   vector_t    vecs [11];

   spi_frame_monitor #(
      .WRITE_CMD  (8'h02),
      .READ_CMD   (8'h0B),
      .DUMMY_BITS (34),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .spi_sclk  (spi_sclk),
      .spi_sdo   (spi_sdo),
      .spi_sdi   (spi_sdi),
      .spi_cs    (spi_cs),
      .rec_valid (rec_valid),
      .rec_ready (rec_ready),
      .rec_cmd   (rec_cmd),
      .rec_addr  (rec_addr),
      .rec_data  (rec_data),
      .rec_err   (rec_err),
      .frame_cnt (frame_cnt),
      .overflow  (overflow)
   );

   // 100 MHz system clock
   always #5 clk_i = ~clk_i;

   // Hard time limit so a stuck design can never hang the run
   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got timeout, required test completion");
      $display("test done: total=%0d bad=%0d", totalChecks + 1, badChecks + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      totalChecks++;
      if (actual !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   // Scoreboard: every record the consumer takes is compared with the
   // oldest expected record, sampled on the falling edge away from updates.
   always @(negedge clk_i) begin
      if (!rst_i && rec_valid && rec_ready) begin
         if (expQ.size() == 0) begin
            totalChecks++;
            badChecks++;
            $display("[TB] FAIL unexpected_record: got cmd=%0h addr=%0h data=%0h err=%0b, required none",
                     rec_cmd, rec_addr, rec_data, rec_err);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("rec_cmd",  rec_cmd,  monExp.cmd);
            checkOutput("rec_addr", rec_addr, monExp.addr);
            checkOutput("rec_data", rec_data, monExp.data);
            checkOutput("rec_err",  rec_err,  monExp.err);
         end
      end
   end

   function automatic bit isValidCmd(input logic [7:0] cmd);
      return (cmd == 8'h02) || (cmd == 8'h0B);
   endfunction

   // Bits sent for an uncut frame; an unknown opcode gets 12 junk bits.
   function automatic int frameBits(input logic [7:0] cmd);
      if (cmd == 8'h0B) return 8 + 32 + 34 + 32;
      if (cmd == 8'h02) return 8 + 32 + 32;
      return 20;
   endfunction

   // Expected record for a frame whose CS rose after 'cut' bits (0 = never
   // cut). Each field holds as many of its leading bits as were delivered.
   function automatic rec_t modelRecord(input frame_t f, input int cut);
      rec_t r;
      int   n;
      int   a;
      int   d;
      r.cmd  = 8'd0;
      r.addr = 32'd0;
      r.data = 32'd0;
      r.err  = 1'b1;
      n = (cut == 0) ? 100000 : cut;
      if (n < 8) begin
         r.cmd = f.cmd >> (8 - n);
         return r;
      end
      r.cmd = f.cmd;
      if (!isValidCmd(f.cmd)) return r;
      a = n - 8;
      if (a < 32) begin
         r.addr = (a == 0) ? 32'd0 : (f.addr >> (32 - a));
         return r;
      end
      r.addr = f.addr;
      d = a - 32 - ((f.cmd == 8'h0B) ? 34 : 0);
      if (d < 0) return r;
      if (d < 32) begin
         r.data = (d == 0) ? 32'd0 : (f.data >> (32 - d));
         return r;
      end
      r.data = f.data;
      r.err  = 1'b0;
      return r;
   endfunction

   // {sdo, sdi} for bit i of a frame. Bits the monitor must ignore (dummy
   // phase, unused direction, junk after a bad opcode) are random.
   function automatic logic [1:0] bitAt(input frame_t f, input int i);
      logic sdo;
      logic sdi;
      int   ds;
      sdo = 1'($urandom);
      sdi = 1'($urandom);
      ds  = (f.cmd == 8'h0B) ? 74 : 40;
      if (i < 8) begin
         sdo = f.cmd[7-i];
      end else if (!isValidCmd(f.cmd)) begin
         sdo = 1'($urandom);
      end else if (i < 40) begin
         sdo = f.addr[39-i];
      end else if (i >= ds && i < ds + 32) begin
         if (f.cmd == 8'h0B) begin
            sdi = f.data[ds+31-i];
            sdo = 1'b0;
         end else begin
            sdo = f.data[ds+31-i];
         end
      end
      return {sdo, sdi};
   endfunction

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic sendBit(input logic [1:0] b);
      spi_sclk = 1'b0;
      spi_sdo  = b[1];
      spi_sdi  = b[0];
      tick();
      spi_sclk = 1'b1;
      tick();
   endtask

   task automatic beginFrame;
      spi_sclk = 1'b0;
      spi_cs   = 1'b0;
      tick();
   endtask

   task automatic sendBits(input frame_t f, input int n);
      for (int i = 0; i < n; i++) begin
         sendBit(bitAt(f, i));
      end
   endtask

   task automatic endFrame;
      spi_sclk = 1'b0;
      tick();
      spi_cs = 1'b1;
      tick();
      tick();
   endtask

   // Queue the record a frame will produce, or note the drop if the
   // consumer is stalled and the FIFO already holds FIFO_DEPTH records.
   task automatic expectRecord(input rec_t e);
      expFrameCnt++;
      if (!rec_ready && expQ.size() >= FIFO_DEPTH) begin
         expOverflow = 1'b1;
      end else begin
         expQ.push_back(e);
      end
   endtask

   task automatic applyStimulus(input frame_t f, input int cut, input bit keepCs,
                                input rec_t e);
      expectRecord(e);
      beginFrame();
      sendBits(f, (cut > 0) ? cut : frameBits(f.cmd));
      if (!keepCs) begin
         endFrame();
      end
      checkOutput("frame_cnt", frame_cnt, expFrameCnt);
      checkOutput("overflow", overflow, expOverflow);
   endtask

   task automatic waitDrain;
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 400) begin
         tick();
         n++;
      end
      checkOutput("drain_pending", expQ.size(), 0);
      checkOutput("drain_valid", rec_valid, 1'b0);
   endtask

   initial begin
      frame_t f;
      frame_t g;
      int     cut;
      bit     keep;
      int     sel;

      // Hand-computed vectors: full frames, back-to-back under CS,
      // truncation in every phase and an unknown opcode
      vecs[0]  = '{'{8'h0B, 32'h64, 32'hDEADBEEF}, 0, 1'b0, '{8'h0B, 32'h64, 32'hDEADBEEF, 1'b0}};
      vecs[1]  = '{'{8'h02, 32'h64, 32'h64}, 0, 1'b1, '{8'h02, 32'h64, 32'h64, 1'b0}};
      vecs[2]  = '{'{8'h0B, 32'h64, 32'h12345678}, 0, 1'b0, '{8'h0B, 32'h64, 32'h12345678, 1'b0}};
      vecs[3]  = '{'{8'h02, 32'h12345678, 32'h0}, 20, 1'b0, '{8'h02, 32'h123, 32'h0, 1'b1}};
      vecs[4]  = '{'{8'h5A, 32'hFFFFFFFF, 32'hFFFFFFFF}, 0, 1'b0, '{8'h5A, 32'h0, 32'h0, 1'b1}};
      vecs[5]  = '{'{8'h0B, 32'h1, 32'h1}, 5, 1'b0, '{8'h01, 32'h0, 32'h0, 1'b1}};
      vecs[6]  = '{'{8'h0B, 32'hCAFEF00D, 32'h1}, 50, 1'b0, '{8'h0B, 32'hCAFEF00D, 32'h0, 1'b1}};
      vecs[7]  = '{'{8'h02, 32'h11, 32'hF0F0F0F0}, 56, 1'b0, '{8'h02, 32'h11, 32'hF0F0, 1'b1}};
      vecs[8]  = '{'{8'h0B, 32'h22, 32'h89ABCDEF}, 82, 1'b0, '{8'h0B, 32'h22, 32'h89, 1'b1}};
      vecs[9]  = '{'{8'h02, 32'hAA, 32'hBB}, 8, 1'b0, '{8'h02, 32'h0, 32'h0, 1'b1}};
      vecs[10] = '{'{8'h02, 32'h80000001, 32'h1}, 72, 1'b0, '{8'h02, 32'h80000001, 32'h1, 1'b0}};

      rst_i     = 1'b1;
      spi_sclk  = 1'b0;
      spi_sdo   = 1'b0;
      spi_sdi   = 1'b0;
      spi_cs    = 1'b1;
      rec_ready = 1'b1;
      repeat (3) tick();
      rst_i = 1'b0;
      tick();

      $display("[TB] reset values");
      checkOutput("rst_valid", rec_valid, 1'b0);
      checkOutput("rst_cmd", rec_cmd, 8'h0);
      checkOutput("rst_addr", rec_addr, 32'h0);
      checkOutput("rst_data", rec_data, 32'h0);
      checkOutput("rst_err", rec_err, 1'b0);
      checkOutput("rst_frame_cnt", frame_cnt, 8'h0);
      checkOutput("rst_overflow", overflow, 1'b0);

      $display("[TB] write frame latency");
      f = '{8'h02, 32'h64, 32'h64};
      expectRecord('{8'h02, 32'h64, 32'h64, 1'b0});
      beginFrame();
      sendBits(f, 71);
      checkOutput("valid_before_last_bit", rec_valid, 1'b0);
      sendBit(bitAt(f, 71));
      checkOutput("valid_after_last_bit", rec_valid, 1'b1);
      endFrame();
      checkOutput("frame_cnt_first", frame_cnt, 8'd1);
      waitDrain();

      $display("[TB] vector table");
      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].f, vecs[i].cut, vecs[i].keepCs, vecs[i].exp);
      end
      waitDrain();

      $display("[TB] random frames");
      for (int i = 0; i < 24; i++) begin
         sel = $urandom_range(0, 3);
         f.cmd  = (sel == 0) ? 8'h02 : (sel == 2) ? 8'($urandom) : 8'h0B;
         f.addr = $urandom;
         f.data = $urandom;
         cut = ($urandom_range(0, 2) == 0) ? $urandom_range(1, frameBits(f.cmd) - 1) : 0;
         keep = (cut == 0 && isValidCmd(f.cmd) && i != 23) ? 1'($urandom_range(0, 1)) : 1'b0;
         applyStimulus(f, cut, keep, modelRecord(f, cut));
      end
      waitDrain();

      $display("[TB] overflow with stalled consumer");
      rec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         g = '{8'h02, 32'h100 + 32'(i), 32'hA0000000 + 32'(i)};
         applyStimulus(g, 0, 1'b0, modelRecord(g, 0));
      end
      checkOutput("ovf_sticky", overflow, 1'b1);
      checkOutput("ovf_head_data", rec_data, 32'hA0000000);
      rec_ready = 1'b1;
      waitDrain();
      checkOutput("ovf_after_drain", overflow, 1'b1);

      $display("[TB] reset in the middle of a read frame");
      rec_ready = 1'b0;
      g = '{8'h02, 32'h55, 32'h66};
      applyStimulus(g, 0, 1'b0, modelRecord(g, 0));
      g = '{8'h0B, 32'h77, 32'h88};
      beginFrame();
      sendBits(g, 40);
      rst_i    = 1'b1;
      spi_sclk = 1'b0;
      spi_cs   = 1'b1;
      tick();
      rst_i = 1'b0;
      checkOutput("midrst_valid", rec_valid, 1'b0);
      checkOutput("midrst_cmd", rec_cmd, 8'h0);
      checkOutput("midrst_addr", rec_addr, 32'h0);
      checkOutput("midrst_data", rec_data, 32'h0);
      checkOutput("midrst_err", rec_err, 1'b0);
      checkOutput("midrst_frame_cnt", frame_cnt, 8'h0);
      checkOutput("midrst_overflow", overflow, 1'b0);
      expQ.delete();
      expFrameCnt = 8'd0;
      expOverflow = 1'b0;
      rec_ready   = 1'b1;
      tick();
      g = '{8'h0B, 32'h64, 32'hDEADBEEF};
      applyStimulus(g, 0, 1'b0, modelRecord(g, 0));
      waitDrain();
      checkOutput("post_rst_frame_cnt", frame_cnt, 8'd1);

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule

// File: doc/spi_frame_monitor.md
# spi_frame_monitor

- Passive SPI bus monitor on the stimulus board, downstream of the SPI stimulus master.
- Decodes each command/address/(dummy)/data frame from the master's SPI outputs, using the same `clk_i` domain.
- Captures read data returned by the SoC on `spi_sdi`.
- Pushes one record per frame into a small FIFO, for on-board checking or UART dump.

## Interface
Parameters:
- `WRITE_CMD`, 8'h02: write-memory opcode (no dummy phase)
- `READ_CMD`, 8'h0B: read-memory opcode (dummy phase, data sampled from `spi_sdi`)
- `DUMMY_BITS`, 34: dummy-phase length in SCLK rising edges
- `FIFO_DEPTH`, 4: record FIFO entries (power of two, ≥2)

Ports:
- `clk_i` in 1: FPGA clock, same clock as the SPI master
- `rst_i` in 1: reset; one clock, synchronous, active-high
- `spi_sclk` in 1: SPI clock from master (registered in `clk_i` domain, toggles at most once per cycle)
- `spi_sdo` in 1: master→SoC data
- `spi_sdi` in 1: SoC→master data (read data)
- `spi_cs` in 1: chip select, active-low
- `rec_valid` out 1: FIFO head record valid
- `rec_ready` in 1: consumer accepts head record
- `rec_cmd` out 8: decoded opcode
- `rec_addr` out 32: decoded address
- `rec_data` out 32: write data (`spi_sdo`) or read data (`spi_sdi`)
- `rec_err` out 1: record is truncated or has an unknown opcode
- `frame_cnt` out 8: frames terminated (complete or error), wraps 255→0
- `overflow` out 1: sticky; a record was dropped because the FIFO was full

## Operation
- Rising SCLK edge detect: `sclk_q` holds the previous-cycle `spi_sclk`; `rise = ~sclk_q & spi_sclk & ~spi_cs`.
- On `rise`, the current phase's shift register shifts in the sampled bit, MSB first. Bit counter is 6 bits, loaded with (phase length − 1), decremented on each `rise`.
- FSM states:
  - IDLE: on `rise`, sample bit 7 of cmd → CMD.
  - CMD: 8 bits total. After the 8th bit: `WRITE_CMD` or `READ_CMD` → ADDR; any other value → push error record {cmd, 0, 0, err=1} → HUNT.
  - ADDR: 32 bits from `spi_sdo`. Then → DUMMY if the opcode is `READ_CMD`, else → DATA.
  - DUMMY: `DUMMY_BITS` rising edges, bits discarded → DATA.
  - DATA: 32 bits. Source is `spi_sdi` for reads, `spi_sdo` for writes. After the 32nd bit, push {cmd, addr, data, err=0}.
    - If `spi_cs` is still low → CMD-ready state, which waits for the next `rise` (back-to-back frames under continuous CS are legal).
    - Otherwise → IDLE.
  - HUNT: ignore bits until `spi_cs`=1 → IDLE.
- Frame boundary: the next frame's first bit is the first `rise` after a completed DATA phase. Frames are delimited by bit count, not by CS.
- CS deasserted (`spi_cs`=1) while in CMD/ADDR/DUMMY/DATA with a partial phase:
  - Push {fields as shifted so far, unshifted fields 0, err=1}.
  - → IDLE.
  - CS high in IDLE or the CMD-ready state is not an error.
- `frame_cnt` increments on every push attempt, including dropped ones.
- FIFO behaviour:
  - Push when full: record dropped, `overflow` ← 1.
  - Push and pop in the same cycle when full: both occur, nothing is dropped, `overflow` unchanged.
  - Pop happens on `rec_valid & rec_ready`.
  - Outputs are driven from the head entry; they are don't-care when `rec_valid`=0.

## Timing
- Reset values:
  - `rec_valid`=0, `rec_cmd`/`rec_addr`/`rec_data`=0, `rec_err`=0, `frame_cnt`=0, `overflow`=0.
  - FSM=IDLE, FIFO empty, `sclk_q`=0.
- Reset mid-frame discards the partial frame and all FIFO contents; no record is produced.
- Latency: final bit sampled in cycle N → FIFO written at the end of N → `rec_valid`=1 in N+1 (if the FIFO was empty).
  - Same for an error push on the CS-rise cycle N.
- Full throughput: SCLK = `clk_i`/2, so a `rise` occurs at most every 2nd cycle. The monitor never misses an edge.
- `overflow` is cleared only by `rst_i`.

## Test plan
- Write frame: cmd 0x02, addr 0x00000064, data 0x00000064; `rec_ready`=1 → one record {02, 00000064, 00000064, err=0} with `rec_valid` high one cycle after the 72nd `rise`; `frame_cnt`=1.
- Read frame: cmd 0x0B, addr 0x64, 34 dummy bits, SoC drives 0xDEADBEEF on `spi_sdi` in DATA, `spi_sdo`=0 there → record {0B, 00000064, DEADBEEF, err=0}.
- Back-to-back: write (0x02/0x64/0x64) then read (0x0B/0x64/0x12345678) with CS low throughout, as the master sequences → two records in order, `frame_cnt`=2, no err.
- Truncation and bad opcode:
  - CS rises after 20 bits of cmd 0x02 + addr bits → record {02, 00000xxx partial, 0, err=1}.
  - A frame with cmd 0x5A → {5A, 0, 0, err=1}; remaining bits ignored until CS high.
- Overflow: 5 write frames with `rec_ready`=0 → 4 records held, `overflow`=1, `frame_cnt`=5. Draining yields frames 1–4 in order.
- Reset: `rst_i` pulsed at bit 40 of a read frame → all outputs return to reset values next cycle. The following full frame decodes correctly.
